// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter.
//   NumReqMin/NumReqMax : legal range of the requester count
//   EomByteDefault      : default end-of-message byte for the message lock
//   log2_ceil()         : index width helper (never narrower than 1 bit)
package uart_tx_arbiter_pkg;

  localparam int unsigned NumReqMin = 2;
  localparam int unsigned NumReqMax = 8;

  localparam logic [7:0] EomByteDefault = 8'h0A;

  function automatic int unsigned log2_ceil(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin search over a request vector.
//   req_i : request vector, one bit per requester
//   ptr_i : index where the search starts; wraps modulo NUM_REQ
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : encoded index of the granted requester (0 when no request)
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = log2_ceil(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  logic        found;
  int unsigned j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte requesters through a
// single-entry holding register with round-robin arbitration.
//   clk, reset          : clock; asynchronous active-high reset
//   req_data/req_valid  : byte offered by each requester (byte i on [8i+7:8i])
//   req_ready           : one-hot accept strobe to the arbitration winner
//   tx_data/tx_valid    : holding register towards the transmitter
//   tx_ready            : transmitter takes the held byte
//   grant_id            : owner of the held byte
//   busy                : register full or message lock held
// Build option: define UART_TX_ARB_MSG_LOCK_EN to keep the grant on one
// requester from its first byte until it sends EOM_BYTE.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter logic [7:0]  EOM_BYTE = EomByteDefault,
  localparam int unsigned IdxW    = log2_ceil(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [IdxW-1:0]      grant_id,
  output logic                 busy
);

  if (NUM_REQ < NumReqMin || NUM_REQ > NumReqMax) begin : gen_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ out of range");
  end

  logic [7:0]         data_q;
  logic [IdxW-1:0]    id_q;
  logic               full_q;
  logic [IdxW-1:0]    rr_ptr_q;

  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IdxW-1:0]    win_idx;
  logic [7:0]         win_data;
  logic               accept_en;
  logic               accept;
  logic               locked;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i (req_masked),
    .ptr_i (rr_ptr_q),
    .gnt_o (win_gnt),
    .idx_o (win_idx)
  );

  // Empty, or draining this cycle: refill without a bubble.
  assign accept_en = !full_q || tx_ready;
  assign accept    = accept_en && !reset && (|req_masked);
  assign win_data  = req_data[8*win_idx +: 8];

  // Reset gating keeps req_ready low while the register is forced empty.
  assign req_ready = (accept_en && !reset) ? win_gnt : '0;

  assign tx_data  = data_q;
  assign tx_valid = full_q;
  assign grant_id = id_q;
  assign busy     = full_q || locked;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= 8'h00;
      id_q     <= '0;
      full_q   <= 1'b0;
      rr_ptr_q <= '0;
    end else if (accept) begin
      data_q   <= win_data;
      id_q     <= win_idx;
      full_q   <= 1'b1;
      rr_ptr_q <= (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (tx_ready) begin
      full_q <= 1'b0;
    end
  end

`ifdef UART_TX_ARB_MSG_LOCK_EN
  logic            lock_q;
  logic [IdxW-1:0] lock_id_q;

  always_comb begin
    req_masked = req_valid;
    if (lock_q) begin
      req_masked = req_valid & (NUM_REQ'(1) << lock_id_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else if (accept) begin
      // Any non-EOM byte (re)arms the lock on its sender; EOM releases it.
      lock_q    <= (win_data != EOM_BYTE);
      lock_id_q <= win_idx;
    end
  end

  assign locked = lock_q;
`else
  logic unused_eom;

  assign req_masked = req_valid;
  assign locked     = 1'b0;
  assign unused_eom = ^EOM_BYTE;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] src[N][8];
  int         len[N];
  int         start[N];
  int         pos[N];

  uart_tx_arbiter #(
    .NUM_REQ  (N),
    .EOM_BYTE (8'h0A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: pops on every transfer the DUT presents.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_transfer: got id %0d data %02h expected none",
                     grant_id, tx_data);
          end else begin
            e = exp_q.pop_front();
            check("sb_tx_data", 32'(tx_data), 32'(e.data));
            check("sb_grant_id", 32'(grant_id), 32'(e.id));
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) begin
      len[i]   = 0;
      start[i] = 0;
    end
  endtask

  // Requesters hold each byte until it is accepted; returns cycles used.
  task automatic run_traffic(input int max_cycles, output int cycles);
    bit done;
    cycles = 0;
    for (int i = 0; i < N; i++) pos[i] = 0;
    forever begin
      done = 1'b1;
      for (int i = 0; i < N; i++) if (pos[i] < len[i]) done = 1'b0;
      if (done) break;
      if (cycles >= max_cycles) begin
        checks++;
        errors++;
        $display("FAIL traffic_timeout: got %0d cycles expected at most %0d", cycles, max_cycles);
        break;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        req_valid[i]      = (pos[i] < len[i]) && (cycles >= start[i]);
        req_data[8*i +: 8] = (pos[i] < len[i]) ? src[i][pos[i]] : 8'h00;
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) pos[i]++;
      cycles++;
    end
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || tx_valid) && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int cyc;
    int bad;

    // Reset state, with requests present to prove req_ready is gated.
    reset     = 1'b1;
    tx_ready  = 1'b1;
    req_valid = '1;
    req_data  = 32'hAABBCCDD;
    clear_src();
    #3;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    @(posedge clk);
    #1 check("rst_tx_valid_edge", 32'(tx_valid), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    fork
      monitor();
    join_none

    // Single requester 2, byte 0x41.
    @(posedge clk);
    #1;
    req_valid           = 4'b0100;
    req_data[23:16]     = 8'h41;
    push(2, 8'h41);
    @(negedge clk);
    check("s1_req_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("s1_tx_valid", 32'(tx_valid), 32'd1);
    check("s1_tx_data", 32'(tx_data), 32'h41);
    check("s1_grant_id", 32'(grant_id), 32'd2);
    check("s1_req_ready_after", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("s1_busy_fall", 32'(busy), 32'd0);

    // All four requesters continuously valid: strict rotation, full rate.
    do_reset();
    clear_src();
    for (int i = 0; i < N; i++) begin
      len[i] = 2;
      for (int k = 0; k < 2; k++) src[i][k] = 8'(16 * i + k);
    end
    push(0, 8'h00); push(1, 8'h10); push(2, 8'h20); push(3, 8'h30);
    push(0, 8'h01); push(1, 8'h11); push(2, 8'h21); push(3, 8'h31);
    run_traffic(40, cyc);
    check("s2_accept_cycles", 32'(cyc), 32'd8);
    wait_drain();
    check("s2_busy_idle", 32'(busy), 32'd0);

    // Back-pressure: byte held stable for 20 cycles, nobody else accepted.
    do_reset();
    @(posedge clk);
    #1;
    tx_ready       = 1'b0;
    req_valid      = 4'b0010;
    req_data[15:8] = 8'h77;
    @(negedge clk);
    check("s3_first_ready", 32'(req_ready), 32'b0010);
    @(posedge clk);
    #1;
    req_valid     = 4'b0001;
    req_data[7:0] = 8'h99;
    push(1, 8'h77);
    push(0, 8'h99);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(tx_valid === 1'b1 && tx_data === 8'h77 && req_ready === 4'b0000 &&
            grant_id === 2'd1 && busy === 1'b1)) bad++;
      @(posedge clk);
      #1;
    end
    check("s3_hold_violations", 32'(bad), 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    check("s3_refill_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();
    check("s3_busy_idle", 32'(busy), 32'd0);

    // Reset mid-transfer discards the held byte.
    do_reset();
    @(posedge clk);
    #1;
    tx_ready        = 1'b0;
    req_valid       = 4'b1000;
    req_data[31:24] = 8'h55;
    @(posedge clk);
    #1 req_valid = '0;
    #1;
    check("s4_held_valid", 32'(tx_valid), 32'd1);
    check("s4_held_data", 32'(tx_data), 32'h55);
    #1 reset = 1'b1;
    #1;
    check("s4_async_valid", 32'(tx_valid), 32'd0);
    check("s4_async_busy", 32'(busy), 32'd0);
    check("s4_async_data", 32'(tx_data), 32'h00);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    tx_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("s4_no_replay", 32'(tx_valid), 32'd0);

    // Req 1 sends "AB\n" while req 0 also has bytes pending.
    do_reset();
    clear_src();
    len[1] = 3; src[1][0] = 8'h41; src[1][1] = 8'h42; src[1][2] = 8'h0A;
    len[0] = 2; src[0][0] = 8'h30; src[0][1] = 8'h31; start[0] = 1;
`ifdef UART_TX_ARB_MSG_LOCK_EN
    push(1, 8'h41); push(1, 8'h42); push(1, 8'h0A); push(0, 8'h30); push(0, 8'h31);
`else
    push(1, 8'h41); push(0, 8'h30); push(1, 8'h42); push(0, 8'h31); push(1, 8'h0A);
`endif
    run_traffic(40, cyc);
    check("s5_accept_cycles", 32'(cyc), 32'd5);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of byte requesters sharing one uart_transmitter; legal range 2..8.
REQ-002 Parameter EOM_BYTE, default 8'h0A: end-of-message byte, used only by the message-lock feature.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_data  input  8*NUM_REQ  byte from requester i on bits [8i+7:8i].
REQ-006 req_valid  input  NUM_REQ  requester i offers a byte.
REQ-007 req_ready  output  NUM_REQ  byte from requester i is accepted this cycle when valid and ready are both high.
REQ-008 tx_data  output  8  byte to the transmitter's data_in.
REQ-009 tx_valid  output  1  drives the transmitter's data_in_valid.
REQ-010 tx_ready  input  1  driven from the transmitter's data_in_ready.
REQ-011 grant_id  output  `log2(NUM_REQ)  index of the requester whose byte currently sits in the holding register.
REQ-012 busy  output  1  high when the holding register is full or a message lock is held.

Function
REQ-013 A single-entry holding register (byte, owner id, full flag) SHALL sit between the requesters and the transmitter; tx_valid equals the full flag; tx_data and grant_id are driven from the register.
REQ-014 The register SHALL be able to accept a byte in a cycle when it is empty, or when it is full and tx_ready is high (drain and refill in the same cycle, giving full throughput).
REQ-015 At most one req_ready bit SHALL be high in any cycle; it SHALL go to the arbitration winner only, and only when REQ-014 permits acceptance.
REQ-016 The winner SHALL be chosen round-robin: search starts at rr_ptr and wraps modulo NUM_REQ.
REQ-017 rr_ptr SHALL be set to (winner+1) mod NUM_REQ on each accepted byte.
REQ-018 Latency: a byte accepted in cycle N SHALL appear on tx_valid/tx_data in cycle N+1.
REQ-019 A held byte SHALL stay stable until tx_ready is sampled high; tx_valid SHALL NOT drop without a transfer.
REQ-020 req_ready SHALL NOT depend combinationally on the req_valid bits of non-winning requesters beyond the arbitration itself.
REQ-021 req_ready SHALL NOT depend on the value of req_data.
REQ-022 With no req_valid bits high, the register drains; busy falls in the cycle after the final transfer.
REQ-023 If all requesters are continuously valid, each SHALL be granted once every NUM_REQ accepted bytes.

Reset
REQ-024 Reset SHALL clear the full flag, the lock and rr_ptr to 0.
REQ-025 During reset: tx_valid=0, req_ready=0, grant_id=0, busy=0, tx_data=8'h00.
REQ-026 Reset asserted mid-transfer SHALL discard the held byte; no partial byte is replayed after reset.

Configuration
REQ-027 Macro UART_TX_ARB_MSG_LOCK_EN defined: after a byte is accepted from requester k, arbitration SHALL be restricted to k until a byte equal to EOM_BYTE is accepted from k; busy stays high while locked.
REQ-028 Macro UART_TX_ARB_MSG_LOCK_EN undefined: arbitration is per byte and EOM_BYTE is ignored.

Structure
REQ-029 NUM_REQ bounds, the default EOM_BYTE and the `log2 helper SHALL live in the shared header util.vh / uart constants package; nothing block-local goes there.
REQ-030 The round-robin search SHALL be a sub-module rr_arbiter (inputs: request vector, pointer; outputs: one-hot grant, encoded index); the holding register and lock logic stay in uart_tx_arbiter.

Verification
REQ-031 Scenario: only req 2 valid, byte 8'h41, tx_ready=1 -> req_ready=4'b0100 for one cycle; next cycle tx_valid=1, tx_data=8'h41, grant_id=2.
REQ-032 Scenario: all 4 requesters valid for 8 accepts, tx_ready=1 -> grant order 0,1,2,3,0,1,2,3; one transfer per cycle after the first.
REQ-033 Scenario: tx_ready held 0 for 20 cycles with a byte held -> tx_data stable, tx_valid=1, all req_ready=0.
REQ-034 Scenario: reset pulsed while holding 8'h55 -> tx_valid=0 asynchronously; 8'h55 never transmitted afterwards.
REQ-035 Scenario, lock enabled: req 1 sends "AB\n" while req 0 is valid -> order A,B,0x0A from req 1, then req 0 granted.
REQ-036 Scenario, lock disabled, same stimulus -> bytes from req 0 and req 1 alternate.
